// File: rtl/md5_rounds_49_to_64_seq.sv
// md5_rounds_49_to_64_seq: sequential MD5 round-4 engine, steps 49-64 one per clock, optional chaining add
module md5_rounds_49_to_64_seq #(
  parameter bit ADD_CHAIN = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] message,
  input  logic [31:0]  chain_a_in,
  input  logic [31:0]  chain_b_in,
  input  logic [31:0]  chain_c_in,
  input  logic [31:0]  chain_d_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [31:0] K [16] = '{
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  state_t       state;
  logic [3:0]   step;
  logic [3:0]   g;
  logic [4:0]   s;
  logic [31:0]  a, b, c, d;
  logic [31:0]  ca, cb, cc, cd;
  logic [511:0] msg;
  logic [31:0]  x, t;
  // one step of the I round: message word index 7*j mod 16, shift amount cycles every four steps
  always_comb begin
    g = step * 4'd7;
    s = step[1:0] == 2'd0 ? 5'd6 : step[1:0] == 2'd1 ? 5'd10 : step[1:0] == 2'd2 ? 5'd15 : 5'd21;
    x = a + (c ^ (b | ~d)) + K[step] + msg[32*g +: 32];
    t = b + ((x << s) | (x >> (6'd32 - {1'b0, s})));
  end
  // control FSM plus working state; the final step writes the rotated state (and chaining sum) straight into the outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      {a, b, c, d}                 <= '0;
      {ca, cb, cc, cd}             <= '0;
      msg                          <= '0;
      {a_out, b_out, c_out, d_out} <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {a, b, c, d}     <= {a_in, b_in, c_in, d_in};
          {ca, cb, cc, cd} <= {chain_a_in, chain_b_in, chain_c_in, chain_d_in};
          msg              <= message;
          step             <= '0;
          in_ready         <= 1'b0;
          state            <= RUN;
        end
        RUN: begin
          {a, b, c, d} <= {d, t, b, c};
          step         <= step + 4'd1;
          if (step == 4'd15) begin
            state     <= DONE;
            out_valid <= 1'b1;
            a_out     <= ADD_CHAIN ? ca + d : d;
            b_out     <= ADD_CHAIN ? cb + t : t;
            c_out     <= ADD_CHAIN ? cc + b : b;
            d_out     <= ADD_CHAIN ? cd + c : c;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_rounds_49_to_64_seq.sv
// tb_md5_rounds_49_to_64_seq: checks the round-4 engine (chained and raw builds) against a full MD5 reference model
module tb_md5_rounds_49_to_64_seq;
  logic         clk = 1'b0;
  logic         resetn, in_valid, out_ready;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] message;
  logic [31:0]  chain_a_in, chain_b_in, chain_c_in, chain_d_in;
  logic         in_ready, out_valid, r_in_ready, r_out_valid;
  logic [31:0]  a_out, b_out, c_out, d_out, r_a, r_b, r_c, r_d;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  md5_rounds_49_to_64_seq #(.ADD_CHAIN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .message(message),
    .chain_a_in(chain_a_in), .chain_b_in(chain_b_in), .chain_c_in(chain_c_in), .chain_d_in(chain_d_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
  );

  md5_rounds_49_to_64_seq #(.ADD_CHAIN(1'b0)) dut_raw (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(r_in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .message(message),
    .chain_a_in(chain_a_in), .chain_b_in(chain_b_in), .chain_c_in(chain_c_in), .chain_d_in(chain_d_in),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .a_out(r_a), .b_out(r_b), .c_out(r_c), .d_out(r_d)
  );

  localparam logic [31:0] KT [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  // plain MD5 compression, steps lo..hi-1 (0-based), state packed {a,b,c,d}
  function automatic logic [127:0] md5_steps(input logic [127:0] st, input logic [511:0] m, input int lo, input int hi);
    logic [31:0] a, b, c, d, f, x, t;
    int g, s;
    {a, b, c, d} = st;
    for (int i = lo; i < hi; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      s = SH[i / 16][i % 4];
      x = a + f + KT[i] + m[32*g +: 32];
      t = b + ((x << s) | (x >> (32 - s)));
      a = d; d = c; c = b; b = t;
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] add4(input logic [127:0] p, input logic [127:0] q);
    for (int i = 0; i < 4; i++) add4[32*i +: 32] = p[32*i +: 32] + q[32*i +: 32];
  endfunction

  function automatic logic [127:0] sub4(input logic [127:0] p, input logic [127:0] q);
    for (int i = 0; i < 4; i++) sub4[32*i +: 32] = p[32*i +: 32] - q[32*i +: 32];
  endfunction

  function automatic logic [511:0] rand512();
    for (int i = 0; i < 16; i++) rand512[32*i +: 32] = $urandom;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [511:0] m, input logic [127:0] st, input logic [127:0] ch);
    message = m;
    {a_in, b_in, c_in, d_in} = st;
    {chain_a_in, chain_b_in, chain_c_in, chain_d_in} = ch;
  endtask

  // one block: accept, scramble inputs, measure latency, hold in DONE, release
  task automatic run_block(input string tag, input logic [511:0] m, input logic [127:0] st, input logic [127:0] ch,
                           input logic [127:0] exp_c, input logic [127:0] exp_r, input int hold);
    int lat;
    logic [127:0] snap;
    chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'd1);
    drive(m, st, ch);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(rand512(), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd16);
    chk({tag, "_chained"}, {a_out, b_out, c_out, d_out}, exp_c);
    chk({tag, "_raw"}, {r_a, r_b, r_c, r_d}, exp_r);
    chk({tag, "_raw_valid"}, 128'(r_out_valid), 128'd1);
    snap = {a_out, b_out, c_out, d_out};
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_stable"}, {a_out, b_out, c_out, d_out, 3'b0, in_ready, 3'b0, out_valid}, {snap, 8'h01});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_release"}, {out_valid, in_ready}, 128'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] iv, st, ce, ca, re;
    logic [511:0] m_e, m_a, m;
    int t1, t2;
    logic [127:0] v1, v2, w1, w2;
    logic seen;
    iv = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    m_e = '0;
    m_e[31:0] = 32'h00000080;
    m_a = '0;
    m_a[31:0] = 32'h80636261;
    m_a[14*32 +: 32] = 32'h00000018;
    ce = {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
    ca = {32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};
    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
    chk("reset_raw_outputs", {r_a, r_b, r_c, r_d, 7'b0, r_out_valid}, 136'd0);
    resetn = 1'b1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    run_block("empty", m_e, md5_steps(iv, m_e, 0, 48), iv, ce, sub4(ce, iv), 5);
    run_block("abc", m_a, md5_steps(iv, m_a, 0, 48), iv, ca, sub4(ca, iv), 0);
    drive(m_e, md5_steps(iv, m_e, 0, 48), iv);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(m_a, md5_steps(iv, m_a, 0, 48), iv);
    t1 = -1;
    t2 = -1;
    v1 = '0; v2 = '0; w1 = '0; w2 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 18) in_valid = 1'b0;
      if (out_valid && t1 < 0) begin
        t1 = i; v1 = {a_out, b_out, c_out, d_out}; w1 = {r_a, r_b, r_c, r_d};
      end else if (out_valid && t2 < 0) begin
        t2 = i; v2 = {a_out, b_out, c_out, d_out}; w2 = {r_a, r_b, r_c, r_d};
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_first_latency", 128'(t1), 128'd16);
    chk("b2b_spacing", 128'(t2 - t1), 128'd18);
    chk("b2b_first_value", v1, ce);
    chk("b2b_second_value", v2, ca);
    chk("b2b_raw_first", w1, sub4(ce, iv));
    chk("b2b_raw_second", w2, sub4(ca, iv));
    drive(m_e, md5_steps(iv, m_e, 0, 48), iv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("midreset_state", {in_ready, out_valid, r_in_ready, r_out_valid}, 128'b1010);
    chk("midreset_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid || r_out_valid) seen = 1'b1;
    end
    chk("midreset_no_output", 128'(seen), 128'd0);
    for (int n = 0; n < 6; n++) begin
      m = rand512();
      st = {$urandom, $urandom, $urandom, $urandom};
      iv = {$urandom, $urandom, $urandom, $urandom};
      re = md5_steps(st, m, 48, 64);
      run_block($sformatf("rand%0d", n), m, st, iv, add4(re, iv), re, int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_rounds_49_to_64_seq.md
Name: md5_rounds_49_to_64_seq

Overview:
- Sequential MD5 round-4 engine: executes steps 49–64 (I function), one step per clock.
- Sits directly downstream of the combinational rounds-33-to-48 stage: consumes its a/b/c/d outputs plus the same 512-bit message block.
- With ADD_CHAIN=1 it also adds the block's initial chaining value, producing the updated MD5 state.
- Valid/ready handshakes on both sides allow back-pressure from the digest consumer.

Parameters:
- ADD_CHAIN, 1, 1: outputs = chain_in words + round-4 result (mod 2^32); 0: raw round-4 a/b/c/d.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous, active-low reset
- in_valid  input  1  a_in..chain_in valid
- in_ready  output  1  engine idle, can accept
- a_in, b_in, c_in, d_in  input  32 each  state after step 48
- message  input  512  word i = message[32*i+31:32*i], i=0..15
- chain_a_in, chain_b_in, chain_c_in, chain_d_in  input  32 each  block's initial chaining value (ignored when ADD_CHAIN=0)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- a_out, b_out, c_out, d_out  output  32 each  result

Behaviour:
- Reset (resetn=0 at posedge):
  - FSM -> IDLE; step counter = 0.
  - out_valid=0; a_out..d_out=0; internal a/b/c/d and message/chain registers = 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts the block; no output is produced.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a..d, message, chain; step=0; -> RUN.
  - RUN: in_ready=0. Each edge performs step j=step, then step++. After the edge with j=15, -> DONE and load the output registers.
  - DONE: out_valid=1; outputs held stable. On out_ready, -> IDLE, out_valid=0 next cycle.
  - in_valid is ignored outside IDLE. The next block is accepted no earlier than the cycle after the out_valid handshake, so there is no overlap.
- Latency:
  - Accept edge at cycle N; 16 RUN edges at N+1..N+16; out_valid=1 from cycle N+16.
  - With out_ready tied high: throughput 1 block / 18 cycles.
- Step j (0..15):
  - I = c ^ (b | ~d).
  - g = (7*j) mod 16, giving 0,7,14,5,12,3,10,1,8,15,6,13,4,11,2,9.
  - s cycles 6,10,15,21.
  - K[j] = f4292244, 432aff97, ab9423a7, fc93a039, 655b59c3, 8f0ccc92, ffeff47d, 85845dd1, 6fa87e4f, fe2ce6e0, a3014314, 4e0811a1, f7537e82, bd3af235, 2ad7d2bb, eb86d391.
  - t = b + rotl32(a + I + K[j] + M[g], s).
  - Update: a<=d, d<=c, c<=b, b<=t.
- Arithmetic: all additions are 32-bit modulo 2^32; carries are discarded.
- Output load:
  - ADD_CHAIN=1: a_out=chain_a+a, b_out=chain_b+b, c_out=chain_c+c, d_out=chain_d+d.
  - ADD_CHAIN=0: raw a, b, c, d.
- Input sampling: message and chain inputs are sampled only at the accept edge; later input changes have no effect.

Test Plan:
- Reset: hold resetn=0 2 cycles -> out_valid=0, a_out..d_out=0, in_ready=1 after release; assert resetn=0 at RUN step 7 -> IDLE, no out_valid.
- Empty-string block: message word0=00000080, others 0; chain=67452301/efcdab89/98badcfe/10325476. a_in..d_in taken from the upstream rounds-1-to-48 chain; ADD_CHAIN=1; out_ready=1.
  - Required: out_valid exactly 16 cycles after accept, with a_out=d98c1dd4, b_out=04b2008f, c_out=980980e9, d_out=7e42f8ec.
- "abc" block: word0=80636261, word14=00000018, others 0; same chain -> a_out=98500190, b_out=b04fd23c, c_out=7d3f96d6, d_out=727fe128.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> out_valid drops next cycle, in_ready=1.
- Back-to-back: in_valid held high with two blocks (empty, "abc"), out_ready=1 -> two results in order, 18 cycles apart, values as above.
- ADD_CHAIN=0: empty-string block -> a_out..d_out equal the above digests minus the chain words (mod 2^32); cross-check against a software reference model.
